line_window_buf: RTL and testbench



---
 rtl/pix_stream_pkg.sv | 30 +++
 rtl/line_delay.sv | 29 ++
 rtl/line_window_buf.sv | 132 +++++++++++++
 tb/tb_line_window_buf.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pix_stream_pkg.sv
// Shared definitions for the pixel-stream blocks: defaults, width helper,
// tap slicing and the line-fill state encoding.
package pix_stream_pkg;

    localparam int unsigned PIX_DATA_W = 8;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } fill_state_e;

    // Ceiling log2, minimum result 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            x = x >> 1;
            r = r + 1;
        end
        return r;
    endfunction

    // LSB position of tap k in a flattened tap column.
    function automatic int unsigned tap_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/line_delay.sv
// One full-line delay: LINE_W-deep pixel memory addressed by column.
// The word stored at addr_i is visible on rd_data_o before the edge, so the
// enabling edge captures the old word downstream while writing the new one.
module line_delay
    import pix_stream_pkg::*;
#(
    parameter int unsigned DATA_W = PIX_DATA_W,
    parameter int unsigned LINE_W = 320,
    localparam int unsigned ADDR_W = clog2(LINE_W)
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [LINE_W];

    assign rd_data_o = mem_q[addr_i];

    // Write the incoming word at the current column on each accepted pixel.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/line_window_buf.sv
// Vertical tap column generator: cascade of NUM_LINES-1 line delays with
// column/fill tracking, frame-start resync and a window-valid flag.
module line_window_buf
    import pix_stream_pkg::*;
#(
    parameter int unsigned DATA_W    = PIX_DATA_W,
    parameter int unsigned LINE_W    = 320,
    parameter int unsigned NUM_LINES = 3,
    localparam int unsigned COL_W    = clog2(LINE_W)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          shift,
    input  logic                          sof,
    input  logic [DATA_W-1:0]             pix_in,
    output logic [NUM_LINES*DATA_W-1:0]   taps,
    output logic [COL_W-1:0]              col_out,
    output logic                          out_valid,
    output logic                          win_valid
);

    localparam int unsigned FILL_W = clog2(NUM_LINES);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(LINE_W - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NUM_LINES - 1);

    logic [COL_W-1:0]            col_q, col_d, col_eff;
    logic [FILL_W-1:0]           fill_q, fill_d, fill_base;
    fill_state_e                 state_q, state_d, state_base;
    logic [NUM_LINES*DATA_W-1:0] taps_q, taps_d;
    logic [COL_W-1:0]            col_out_q;
    logic                        out_valid_q;
    logic                        win_valid_q, win_d;

    logic [DATA_W-1:0] rd_data [1:NUM_LINES-1];

    // sof overrides the counters for the pixel it qualifies
    assign col_eff    = sof ? '0 : col_q;
    assign fill_base  = sof ? '0 : fill_q;
    assign state_base = sof ? FILL : state_q;

    genvar gk;
    generate
        for (gk = 1; gk < NUM_LINES; gk++) begin : g_dly
            logic [DATA_W-1:0] wr_data;
            if (gk == 1) begin : g_first
                assign wr_data = pix_in;
            end else begin : g_casc
                assign wr_data = rd_data[gk-1];
            end
            line_delay #(
                .DATA_W (DATA_W),
                .LINE_W (LINE_W)
            ) u_dly (
                .clk       (clk),
                .en_i      (shift),
                .addr_i    (col_eff),
                .wr_data_i (wr_data),
                .rd_data_o (rd_data[gk])
            );
        end
    endgenerate

    // Next column, fill count, FSM state, window flag and tap column.
    always_comb begin
        col_d   = col_q;
        fill_d  = fill_q;
        state_d = state_q;
        win_d   = 1'b0;
        taps_d  = taps_q;
        if (shift) begin
            col_d  = (col_eff == COL_LAST) ? '0 : col_eff + COL_W'(1);
            fill_d = fill_base;
            if ((col_eff == COL_LAST) && (fill_base != FILL_MAX)) begin
                fill_d = fill_base + FILL_W'(1);
            end
            case (state_base)
                FILL: begin
                    win_d   = 1'b0;
                    state_d = (fill_d == FILL_MAX) ? STREAM : FILL;
                end
                STREAM: begin
                    win_d   = 1'b1;
                    state_d = STREAM;
                end
                default: begin
                    win_d   = 1'b0;
                    state_d = FILL;
                end
            endcase
            taps_d[DATA_W-1:0] = pix_in;
            for (int unsigned k = 1; k < NUM_LINES; k++) begin
                taps_d[tap_lsb(k, DATA_W) +: DATA_W] = rd_data[k];
            end
        end
    end

    // Counter and FSM state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q   <= '0;
            fill_q  <= '0;
            state_q <= FILL;
        end else begin
            col_q   <= col_d;
            fill_q  <= fill_d;
            state_q <= state_d;
        end
    end

    // Output registers: taps/col hold when idle, valid flags pulse per accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taps_q      <= '0;
            col_out_q   <= '0;
            out_valid_q <= 1'b0;
            win_valid_q <= 1'b0;
        end else begin
            taps_q      <= taps_d;
            out_valid_q <= shift;
            win_valid_q <= win_d;
            if (shift) begin
                col_out_q <= col_eff;
            end
        end
    end

    assign taps      = taps_q;
    assign col_out   = col_out_q;
    assign out_valid = out_valid_q;
    assign win_valid = win_valid_q;

endmodule

// File: tb/tb_line_window_buf.sv
module tb_line_window_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        shift_a, sof_a;
    logic [7:0]  pix_a;
    logic [23:0] taps_a;
    logic [1:0]  col_a;
    logic        ov_a, wv_a;

    logic        shift_b, sof_b;
    logic [7:0]  pix_b;
    logic [39:0] taps_b;
    logic [2:0]  col_b;
    logic        ov_b, wv_b;

    int checks = 0;
    int errors = 0;

    line_window_buf #(.DATA_W(8), .LINE_W(4), .NUM_LINES(3)) dut_a (
        .clk(clk), .reset_n(rst_n), .shift(shift_a), .sof(sof_a), .pix_in(pix_a),
        .taps(taps_a), .col_out(col_a), .out_valid(ov_a), .win_valid(wv_a)
    );

    line_window_buf #(.DATA_W(8), .LINE_W(6), .NUM_LINES(5)) dut_b (
        .clk(clk), .reset_n(rst_n), .shift(shift_b), .sof(sof_b), .pix_in(pix_b),
        .taps(taps_b), .col_out(col_b), .out_valid(ov_b), .win_valid(wv_b)
    );

    // Expected tap column for pixel (r,c) of a frame whose pixels are r*16+c.
    function automatic logic [39:0] model_taps(input int r, input int c, input int nl);
        logic [39:0] e;
        e = '0;
        for (int k = 0; k < nl; k++)
            if (r >= k) e[k*8 +: 8] = 8'((r - k) * 16 + c);
        return e;
    endfunction

    // Only taps reaching back into the current frame are defined.
    function automatic logic [39:0] tap_mask(input int r, input int nl);
        logic [39:0] m;
        m = '0;
        for (int k = 0; k < nl; k++)
            if (r >= k) m[k*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic drive_a(input logic s, input logic sf, input logic [7:0] p);
        shift_a = s; sof_a = sf; pix_a = p;
        @(posedge clk); #1;
        shift_a = 1'b0; sof_a = 1'b0;
    endtask

    task automatic drive_b(input logic s, input logic sf, input logic [7:0] p);
        shift_b = s; sof_b = sf; pix_b = p;
        @(posedge clk); #1;
        shift_b = 1'b0; sof_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (taps_a !== 24'h0) begin errors++; $display("FAIL reset_taps_a got %h want 0", taps_a); end
        checks++; if (col_a !== 2'd0) begin errors++; $display("FAIL reset_col_a got %0d want 0", col_a); end
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_ov_a got %b want 0", ov_a); end
        checks++; if (wv_a !== 1'b0) begin errors++; $display("FAIL reset_wv_a got %b want 0", wv_a); end
        checks++; if (taps_b !== 40'h0) begin errors++; $display("FAIL reset_taps_b got %h want 0", taps_b); end
        checks++; if (ov_b !== 1'b0) begin errors++; $display("FAIL reset_ov_b got %b want 0", ov_b); end
        rst_n = 1'b1;
        drive_a(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_fill();
        int r, c;
        logic [39:0] e, m;
        for (int i = 0; i < 12; i++) begin
            r = i / 4; c = i % 4;
            drive_a(1'b1, i == 0, 8'(r * 16 + c));
            e = model_taps(r, c, 3); m = tap_mask(r, 3);
            checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL fill_ov i=%0d got %b want 1", i, ov_a); end
            checks++; if (col_a !== 2'(c)) begin errors++; $display("FAIL fill_col i=%0d got %0d want %0d", i, col_a, c); end
            checks++; if (wv_a !== 1'(i >= 8)) begin errors++; $display("FAIL fill_wv i=%0d got %b want %b", i, wv_a, i >= 8); end
            checks++; if ((taps_a & m[23:0]) !== (e[23:0] & m[23:0])) begin errors++; $display("FAIL fill_taps i=%0d got %h want %h", i, taps_a, e[23:0]); end
            if (i == 9) begin
                checks++; if (taps_a !== 24'h01_11_21) begin errors++; $display("FAIL fill_r2c1 got %h want 011121", taps_a); end
            end
        end
        drive_a(1'b0, 1'b0, 8'h00);
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL fill_idle_ov got %b want 0", ov_a); end
        checks++; if (wv_a !== 1'b0) begin errors++; $display("FAIL fill_idle_wv got %b want 0", wv_a); end
    endtask

    task automatic test_gapped();
        int r, c;
        logic [39:0] e, m;
        for (int i = 0; i < 12; i++) begin
            r = i / 4; c = i % 4;
            e = model_taps(r, c, 3); m = tap_mask(r, 3);
            drive_a(1'b1, i == 0, 8'(r * 16 + c));
            checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL gap_ov i=%0d got %b want 1", i, ov_a); end
            checks++; if (wv_a !== 1'(i >= 8)) begin errors++; $display("FAIL gap_wv i=%0d got %b want %b", i, wv_a, i >= 8); end
            checks++; if ((taps_a & m[23:0]) !== (e[23:0] & m[23:0])) begin errors++; $display("FAIL gap_taps i=%0d got %h want %h", i, taps_a, e[23:0]); end
            for (int g = 0; g < 2; g++) begin
                drive_a(1'b0, 1'b0, 8'hFF);
                checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL gap_idle_ov i=%0d got %b want 0", i, ov_a); end
                checks++; if (wv_a !== 1'b0) begin errors++; $display("FAIL gap_idle_wv i=%0d got %b want 0", i, wv_a); end
                checks++; if (col_a !== 2'(c)) begin errors++; $display("FAIL gap_hold_col i=%0d got %0d want %0d", i, col_a, c); end
                checks++; if ((taps_a & m[23:0]) !== (e[23:0] & m[23:0])) begin errors++; $display("FAIL gap_hold_taps i=%0d got %h want %h", i, taps_a, e[23:0]); end
            end
        end
    endtask

    task automatic test_sof_mid();
        int r, c;
        logic [7:0] p;
        for (int i = 0; i < 10; i++)
            drive_a(1'b1, i == 0, 8'((i / 4) * 16 + i % 4));
        for (int j = 0; j < 9; j++) begin
            r = j / 4; c = j % 4;
            p = (j == 0) ? 8'hA0 : 8'(r * 16 + c);
            drive_a(1'b1, j == 0, p);
            checks++; if (col_a !== 2'(c)) begin errors++; $display("FAIL sof_col j=%0d got %0d want %0d", j, col_a, c); end
            checks++; if (wv_a !== 1'(j >= 8)) begin errors++; $display("FAIL sof_wv j=%0d got %b want %b", j, wv_a, j >= 8); end
            if (j == 0) begin
                checks++; if (taps_a[7:0] !== 8'hA0) begin errors++; $display("FAIL sof_tap0 got %h want a0", taps_a[7:0]); end
            end
            if (j == 8) begin
                checks++; if (taps_a !== 24'hA0_10_20) begin errors++; $display("FAIL sof_r2c0 got %h want a01020", taps_a); end
            end
        end
    endtask

    task automatic test_continuous();
        int r, c;
        logic [39:0] e, m;
        for (int i = 0; i < 20; i++) begin
            r = i / 4; c = i % 4;
            drive_a(1'b1, i == 0, 8'(r * 16 + c));
            e = model_taps(r, c, 3); m = tap_mask(r, 3);
            checks++; if (col_a !== 2'(c)) begin errors++; $display("FAIL cont_col i=%0d got %0d want %0d", i, col_a, c); end
            checks++; if (wv_a !== 1'(i >= 8)) begin errors++; $display("FAIL cont_wv i=%0d got %b want %b", i, wv_a, i >= 8); end
            checks++; if ((taps_a & m[23:0]) !== (e[23:0] & m[23:0])) begin errors++; $display("FAIL cont_taps i=%0d got %h want %h", i, taps_a, e[23:0]); end
            if (i == 19) begin
                checks++; if (taps_a !== 24'h23_33_43) begin errors++; $display("FAIL cont_r4c3 got %h want 233343", taps_a); end
            end
        end
    endtask

    task automatic test_async_reset();
        drive_a(1'b1, 1'b0, 8'h50);
        drive_a(1'b1, 1'b0, 8'h51);
        checks++; if (col_a !== 2'd1 || wv_a !== 1'b1 || ov_a !== 1'b1) begin errors++; $display("FAIL arst_pre got col=%0d wv=%b ov=%b want 1 1 1", col_a, wv_a, ov_a); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (taps_a !== 24'h0) begin errors++; $display("FAIL arst_taps got %h want 0", taps_a); end
        checks++; if (col_a !== 2'd0) begin errors++; $display("FAIL arst_col got %0d want 0", col_a); end
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL arst_ov got %b want 0", ov_a); end
        checks++; if (wv_a !== 1'b0) begin errors++; $display("FAIL arst_wv got %b want 0", wv_a); end
        #1 rst_n = 1'b1;
        drive_a(1'b1, 1'b0, 8'h77);
        checks++; if (col_a !== 2'd0) begin errors++; $display("FAIL arst_next_col got %0d want 0", col_a); end
        checks++; if (wv_a !== 1'b0) begin errors++; $display("FAIL arst_next_wv got %b want 0", wv_a); end
        checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL arst_next_ov got %b want 1", ov_a); end
        checks++; if (taps_a[7:0] !== 8'h77) begin errors++; $display("FAIL arst_next_tap0 got %h want 77", taps_a[7:0]); end
    endtask

    task automatic test_deep();
        int r, c;
        logic [39:0] e, m;
        for (int i = 0; i < 30; i++) begin
            r = i / 6; c = i % 6;
            drive_b(1'b1, i == 0, 8'(r * 16 + c));
            e = model_taps(r, c, 5); m = tap_mask(r, 5);
            checks++; if (col_b !== 3'(c)) begin errors++; $display("FAIL deep_col i=%0d got %0d want %0d", i, col_b, c); end
            checks++; if (wv_b !== 1'(i >= 24)) begin errors++; $display("FAIL deep_wv i=%0d got %b want %b", i, wv_b, i >= 24); end
            checks++; if ((taps_b & m) !== (e & m)) begin errors++; $display("FAIL deep_taps i=%0d got %h want %h", i, taps_b, e); end
            if (i == 24) begin
                checks++; if (taps_b !== 40'h00_10_20_30_40) begin errors++; $display("FAIL deep_r4c0 got %h want 0010203040", taps_b); end
                checks++; if (taps_b[39:32] !== 8'h00) begin errors++; $display("FAIL deep_tap4 got %h want 00", taps_b[39:32]); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        shift_a = 1'b0; sof_a = 1'b0; pix_a = '0;
        shift_b = 1'b0; sof_b = 1'b0; pix_b = '0;
        test_reset();
        test_fill();
        test_gapped();
        test_sof_mid();
        test_continuous();
        test_async_reset();
        test_deep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
